// File: rtl/bf_defs.sv
// Shared encodings for the brainfuck-style core: opcodes used by the decoder
// and loop unit, plus the loop unit's FSM states.
package bf_defs;

    localparam int unsigned OPCODE_WIDTH = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP        = 3'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_INC        = 3'd1;  // '+'
    localparam logic [OPCODE_WIDTH-1:0] OP_DEC        = 3'd2;  // '-'
    localparam logic [OPCODE_WIDTH-1:0] OP_RIGHT      = 3'd3;  // '>'
    localparam logic [OPCODE_WIDTH-1:0] OP_LEFT       = 3'd4;  // '<'
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT        = 3'd5;  // '.'
    localparam logic [OPCODE_WIDTH-1:0] OP_LOOP_OPEN  = 3'd6;  // '['
    localparam logic [OPCODE_WIDTH-1:0] OP_LOOP_CLOSE = 3'd7;  // ']'

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_SKIP = 2'd1,
        ST_ERR  = 2'd2
    } loop_state_e;

endpackage

// File: rtl/loop_unit_nest_counter.sv
// Forward-skip nesting counter: load to 1, increment, decrement, flags.
module nest_counter #(
    parameter int unsigned NEST_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  inc,
    input  logic                  dec,
    output logic [NEST_WIDTH-1:0] count,
    output logic                  all_ones,
    output logic                  is_one
);

    logic [NEST_WIDTH-1:0] count_q;
    logic [NEST_WIDTH-1:0] count_d;

    // Next count: load wins over inc, inc over dec.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = NEST_WIDTH'(1);
        end else if (inc) begin
            count_d = count_q + NEST_WIDTH'(1);
        end else if (dec) begin
            count_d = count_q - NEST_WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign all_ones = &count_q;
    assign is_one   = (count_q == NEST_WIDTH'(1));

endmodule

// File: rtl/loop_unit.sv
// Loop control unit: pushes return addresses on '[', jumps back on ']',
// skips forward over loop bodies entered with a zero cell, and latches
// stack overflow/underflow and nesting overflow into a sticky error state.
//
// Handshake: instr_valid qualifies opcode/pc for one cycle; every strobe is a
// single-cycle combinational pulse that the stack/fetch consume on the next
// rising clk edge. There is no back-pressure.
module loop_unit
    import bf_defs::*;
#(
    parameter int unsigned PC_WIDTH         = 8,
    parameter int unsigned STACK_ADDR_WIDTH = 5,
    parameter int unsigned NEST_WIDTH       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      instr_valid,
    input  logic [2:0]                opcode,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic                      cell_zero,
    input  logic [PC_WIDTH-1:0]       stack_top,
    output logic                      stack_push,
    output logic                      stack_pop,
    output logic [PC_WIDTH-1:0]       stack_pushd,
    output logic                      pc_load,
    output logic [PC_WIDTH-1:0]       pc_target,
    output logic                      exec_en,
    output logic                      skipping,
    output logic                      error,
    output logic [STACK_ADDR_WIDTH:0] depth,
    output loop_state_e               dbg_state
);

    localparam logic [STACK_ADDR_WIDTH:0] DEPTH_MAX =
        (STACK_ADDR_WIDTH+1)'(2**STACK_ADDR_WIDTH);

    loop_state_e               state_q, state_d;
    logic [STACK_ADDR_WIDTH:0] depth_q, depth_d;

    logic                  cnt_load, cnt_inc, cnt_dec;
    logic [NEST_WIDTH-1:0] cnt_value;
    logic                  cnt_all_ones, cnt_is_one;

    nest_counter #(
        .NEST_WIDTH(NEST_WIDTH)
    ) u_nest (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .all_ones (cnt_all_ones),
        .is_one   (cnt_is_one)
    );

    // Next-state, depth and strobe decode; rst forces every strobe low.
    always_comb begin
        state_d    = state_q;
        depth_d    = depth_q;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        pc_load    = 1'b0;
        exec_en    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_dec    = 1'b0;

        if (instr_valid && !rst) begin
            case (state_q)
                ST_RUN: begin
                    if (opcode == OP_LOOP_OPEN) begin
                        if (cell_zero) begin
                            state_d  = ST_SKIP;
                            cnt_load = 1'b1;
                        end else if (depth_q == DEPTH_MAX) begin
                            state_d = ST_ERR;
                        end else begin
                            stack_push = 1'b1;
                            depth_d    = depth_q + (STACK_ADDR_WIDTH+1)'(1);
                        end
                    end else if (opcode == OP_LOOP_CLOSE) begin
                        // An unmatched ']' is an error whatever the cell holds.
                        if (depth_q == '0) begin
                            state_d = ST_ERR;
                        end else if (cell_zero) begin
                            stack_pop = 1'b1;
                            depth_d   = depth_q - (STACK_ADDR_WIDTH+1)'(1);
                        end else begin
                            pc_load = 1'b1;
                        end
                    end else begin
                        exec_en = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (opcode == OP_LOOP_OPEN) begin
                        if (cnt_all_ones) begin
                            state_d = ST_ERR;
                        end else begin
                            cnt_inc = 1'b1;
                        end
                    end else if (opcode == OP_LOOP_CLOSE) begin
                        cnt_dec = 1'b1;
                        if (cnt_is_one) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    // ST_ERR: sticky until reset.
                end
            endcase
        end
    end

    // State and depth registers; reset treats the external stack as empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
        end
    end

    assign stack_pushd = pc + PC_WIDTH'(1);
    assign pc_target   = stack_top;
    assign skipping    = (state_q == ST_SKIP) && !rst;
    assign error       = (state_q == ST_ERR);
    assign depth       = depth_q;
    assign dbg_state   = state_q;

    logic unused_cnt;
    assign unused_cnt = ^cnt_value;

endmodule

// File: tb/tb_loop_unit.sv
// Directed bench for loop_unit: stack push/jump/pop, forward skip, overflow,
// underflow, nesting overflow and reset behaviour.
module tb_loop_unit;
    import bf_defs::*;

    localparam int unsigned PW = 8;
    localparam int unsigned SAW = 5;

    logic            clk;
    logic            rst;
    logic            instr_valid;
    logic [2:0]      opcode;
    logic [PW-1:0]   pc;
    logic            cell_zero;
    logic [PW-1:0]   stack_top;
    logic            stack_push;
    logic            stack_pop;
    logic [PW-1:0]   stack_pushd;
    logic            pc_load;
    logic [PW-1:0]   pc_target;
    logic            exec_en;
    logic            skipping;
    logic            error;
    logic [SAW:0]    depth;
    loop_state_e     dbg_state;

    int checks = 0;
    int errors = 0;

    loop_unit #(
        .PC_WIDTH(PW),
        .STACK_ADDR_WIDTH(SAW),
        .NEST_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .pc          (pc),
        .cell_zero   (cell_zero),
        .stack_top   (stack_top),
        .stack_push  (stack_push),
        .stack_pop   (stack_pop),
        .stack_pushd (stack_pushd),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .exec_en     (exec_en),
        .skipping    (skipping),
        .error       (error),
        .depth       (depth),
        .dbg_state   (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1ns after a rising edge.
    task automatic drive(input logic v, input logic [2:0] op, input logic [PW-1:0] p,
                         input logic cz, input logic [PW-1:0] st);
        instr_valid = v;
        opcode      = op;
        pc          = p;
        cell_zero   = cz;
        stack_top   = st;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, OP_LOOP_OPEN, 8'd3, 1'b0, 8'd0);
        checks++;
        if (stack_push !== 1'b0) begin errors++; $display("FAIL rst_push got %0b exp 0", stack_push); end
        drive(1'b1, OP_INC, 8'd3, 1'b0, 8'd0);
        checks++;
        if (exec_en !== 1'b0) begin errors++; $display("FAIL rst_exec got %0b exp 0", exec_en); end
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        checks++;
        if (depth !== 6'd0) begin errors++; $display("FAIL rst_depth got %0d exp 0", depth); end
        checks++;
        if (error !== 1'b0 || skipping !== 1'b0) begin
            errors++; $display("FAIL rst_flags got err=%0b skip=%0b exp 0 0", error, skipping);
        end
        checks++;
        if (dbg_state !== ST_RUN) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_RUN); end
    endtask

    task automatic test_open_close();
        drive(1'b1, OP_LOOP_OPEN, 8'd4, 1'b0, 8'd0);
        checks++;
        if (stack_push !== 1'b1 || stack_pushd !== 8'd5 || stack_pop !== 1'b0) begin
            errors++; $display("FAIL open_push got push=%0b d=%0d pop=%0b exp 1 5 0", stack_push, stack_pushd, stack_pop);
        end
        tick();
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        checks++;
        if (depth !== 6'd1) begin errors++; $display("FAIL open_depth got %0d exp 1", depth); end
        drive(1'b1, OP_LOOP_CLOSE, 8'd9, 1'b0, 8'd5);
        checks++;
        if (pc_load !== 1'b1 || pc_target !== 8'd5 || stack_pop !== 1'b0) begin
            errors++; $display("FAIL close_jump got ld=%0b tgt=%0d pop=%0b exp 1 5 0", pc_load, pc_target, stack_pop);
        end
        tick();
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        checks++;
        if (depth !== 6'd1) begin errors++; $display("FAIL close_jump_depth got %0d exp 1", depth); end
        drive(1'b1, OP_LOOP_CLOSE, 8'd9, 1'b1, 8'hA5);
        checks++;
        if (stack_pop !== 1'b1 || pc_load !== 1'b0 || stack_push !== 1'b0 || pc_target !== 8'hA5) begin
            errors++; $display("FAIL close_pop got pop=%0b ld=%0b push=%0b tgt=%0h exp 1 0 0 a5",
                               stack_pop, pc_load, stack_push, pc_target);
        end
        tick();
        drive(1'b1, OP_LOOP_OPEN, 8'd7, 1'b0, 8'd0);
        instr_valid = 1'b0;
        #1;
        checks++;
        if (depth !== 6'd0) begin errors++; $display("FAIL close_pop_depth got %0d exp 0", depth); end
        checks++;
        if (stack_push !== 1'b0 || exec_en !== 1'b0) begin
            errors++; $display("FAIL idle_strobes got push=%0b exec=%0b exp 0 0", stack_push, exec_en);
        end
        tick();
        checks++;
        if (depth !== 6'd0) begin errors++; $display("FAIL idle_depth got %0d exp 0", depth); end
    endtask

    task automatic test_skip();
        logic [2:0] ops [5];
        ops[0] = OP_LOOP_OPEN; ops[1] = OP_INC; ops[2] = OP_LOOP_CLOSE;
        ops[3] = OP_DEC;       ops[4] = OP_LOOP_CLOSE;
        drive(1'b1, OP_LOOP_OPEN, 8'd10, 1'b1, 8'd0);
        checks++;
        if (stack_push !== 1'b0 || exec_en !== 1'b0) begin
            errors++; $display("FAIL skip_enter got push=%0b exec=%0b exp 0 0", stack_push, exec_en);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ops[i], 8'(11 + i), 1'b0, 8'd0);
            checks++;
            if (skipping !== 1'b1 || exec_en !== 1'b0 || stack_push !== 1'b0 || stack_pop !== 1'b0 || pc_load !== 1'b0) begin
                errors++; $display("FAIL skip_body%0d got skip=%0b exec=%0b push=%0b pop=%0b ld=%0b exp 1 0 0 0 0",
                                   i, skipping, exec_en, stack_push, stack_pop, pc_load);
            end
            tick();
        end
        drive(1'b1, OP_INC, 8'hFF, 1'b0, 8'd0);
        checks++;
        if (skipping !== 1'b0 || exec_en !== 1'b1) begin
            errors++; $display("FAIL skip_exit got skip=%0b exec=%0b exp 0 1", skipping, exec_en);
        end
        checks++;
        if (stack_pushd !== 8'd0) begin errors++; $display("FAIL pushd_wrap got %0d exp 0", stack_pushd); end
        tick();
    endtask

    task automatic test_overflow();
        int pushes;
        pushes = 0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, OP_LOOP_OPEN, 8'(i), 1'b0, 8'd0);
            if (stack_push === 1'b1) pushes++;
            tick();
        end
        checks++;
        if (pushes != 32) begin errors++; $display("FAIL ovf_pushes got %0d exp 32", pushes); end
        checks++;
        if (depth !== 6'd32) begin errors++; $display("FAIL ovf_depth got %0d exp 32", depth); end
        drive(1'b1, OP_LOOP_OPEN, 8'd40, 1'b0, 8'd0);
        checks++;
        if (stack_push !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL ovf_33rd got push=%0b err=%0b exp 0 0", stack_push, error);
        end
        tick();
        drive(1'b1, OP_INC, 8'd41, 1'b0, 8'd0);
        checks++;
        if (error !== 1'b1 || exec_en !== 1'b0 || depth !== 6'd32) begin
            errors++; $display("FAIL ovf_err got err=%0b exec=%0b depth=%0d exp 1 0 32", error, exec_en, depth);
        end
        tick();
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", error); end
        apply_reset();
    endtask

    task automatic test_underflow();
        drive(1'b1, OP_LOOP_CLOSE, 8'd2, 1'b1, 8'd0);
        checks++;
        if (stack_pop !== 1'b0 || pc_load !== 1'b0) begin
            errors++; $display("FAIL unf_strobes got pop=%0b ld=%0b exp 0 0", stack_pop, pc_load);
        end
        tick();
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL unf_err got %0b exp 1", error); end
        apply_reset();
        checks++;
        if (error !== 1'b0 || depth !== 6'd0) begin
            errors++; $display("FAIL unf_reset got err=%0b depth=%0d exp 0 0", error, depth);
        end
    endtask

    task automatic test_reset_in_skip();
        drive(1'b1, OP_LOOP_OPEN, 8'd1, 1'b1, 8'd0);
        tick();
        drive(1'b1, OP_LOOP_OPEN, 8'd2, 1'b0, 8'd0);
        tick();
        drive(1'b1, OP_LOOP_OPEN, 8'd3, 1'b0, 8'd0);
        tick();
        checks++;
        if (skipping !== 1'b1) begin errors++; $display("FAIL rskip_pre got %0b exp 1", skipping); end
        rst = 1'b1;
        drive(1'b1, OP_INC, 8'd4, 1'b0, 8'd0);
        checks++;
        if (skipping !== 1'b0 || exec_en !== 1'b0) begin
            errors++; $display("FAIL rskip_during got skip=%0b exec=%0b exp 0 0", skipping, exec_en);
        end
        tick();
        rst = 1'b0;
        drive(1'b1, OP_INC, 8'd5, 1'b0, 8'd0);
        checks++;
        if (skipping !== 1'b0 || exec_en !== 1'b1) begin
            errors++; $display("FAIL rskip_after got skip=%0b exec=%0b exp 0 1", skipping, exec_en);
        end
        tick();
    endtask

    task automatic test_nest_overflow();
        drive(1'b1, OP_LOOP_OPEN, 8'd0, 1'b1, 8'd0);
        tick();
        for (int i = 0; i < 254; i++) begin
            drive(1'b1, OP_LOOP_OPEN, 8'(i), 1'b0, 8'd0);
            tick();
        end
        checks++;
        if (skipping !== 1'b1 || error !== 1'b0) begin
            errors++; $display("FAIL nest_full got skip=%0b err=%0b exp 1 0", skipping, error);
        end
        drive(1'b1, OP_LOOP_OPEN, 8'd9, 1'b0, 8'd0);
        tick();
        checks++;
        if (error !== 1'b1 || skipping !== 1'b0) begin
            errors++; $display("FAIL nest_ovf got err=%0b skip=%0b exp 1 0", error, skipping);
        end
        apply_reset();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, OP_NOP, 8'd0, 1'b0, 8'd0);
        tick();
        test_reset();
        test_open_close();
        test_skip();
        test_overflow();
        test_underflow();
        test_reset_in_skip();
        test_nest_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/loop_unit.md
LOOP_UNIT -- requirements
Module: loop_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, width of instruction addresses and of stack entries.
REQ-002 SHALL have parameter STACK_ADDR_WIDTH, default 5, log2 of the downstream stack capacity (capacity 32).
REQ-003 SHALL have parameter NEST_WIDTH, default 8, width of the forward-skip nesting counter.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 instr_valid in 1; opcode and pc are valid this cycle.
REQ-006 opcode in 3; decoded instruction, encodings from the shared package.
REQ-007 pc in PC_WIDTH; address of the current instruction.
REQ-008 cell_zero in 1; current data cell equals 0.
REQ-009 stack_top in PC_WIDTH; top-of-stack value from the downstream LIFO.
REQ-010 stack_push out 1; stack_pop out 1; stack_pushd out PC_WIDTH; drive the LIFO's push enable, pop enable and push data.
REQ-011 pc_load out 1; pc_target out PC_WIDTH; redirect fetch to pc_target at the next edge.
REQ-012 exec_en out 1; a non-loop instruction may execute this cycle.
REQ-013 skipping out 1; error out 1; depth out STACK_ADDR_WIDTH+1, current stack occupancy.

Function
REQ-014 SHALL implement states RUN, SKIP, ERR; state, skip counter and depth registered; strobes combinational from state and inputs; consumer acts on the next clk edge.
REQ-015 RUN, instr_valid, opcode LOOP_OPEN, cell_zero=0: stack_push=1, stack_pushd=pc+1 (mod 2^PC_WIDTH), depth+1.
REQ-016 RUN, LOOP_OPEN, cell_zero=1: no push; next state SKIP; skip counter loaded with 1.
REQ-017 RUN, LOOP_CLOSE, cell_zero=0: pc_load=1, pc_target=stack_top; no pop; depth unchanged.
REQ-018 RUN, LOOP_CLOSE, cell_zero=1: stack_pop=1, depth-1; fetch continues sequentially.
REQ-019 RUN, any other opcode with instr_valid: exec_en=1; all other strobes 0.
REQ-020 SKIP: exec_en=0, skipping=1; LOOP_OPEN increments and LOOP_CLOSE decrements the skip counter; no stack activity.
REQ-021 SKIP, LOOP_CLOSE with skip counter 1: next state RUN, skipping=0 from the following cycle.
REQ-022 instr_valid=0: no strobes, no state or counter change in any state.
REQ-023 Overflow: LOOP_OPEN with cell_zero=0 at depth = 2^STACK_ADDR_WIDTH SHALL NOT push; next state ERR.
REQ-024 Underflow: LOOP_CLOSE in RUN at depth 0 SHALL NOT pop or load; next state ERR.
REQ-025 Skip counter at all-ones receiving LOOP_OPEN: next state ERR.
REQ-026 ERR: error=1, all strobes 0; held until rst.
REQ-027 stack_push and stack_pop SHALL never be high in the same cycle.
REQ-028 pc_target SHALL equal stack_top whenever pc_load=0; stack_pushd SHALL equal pc+1 at all times.

Reset
REQ-029 rst high at a clk edge: state RUN, depth 0, skip counter 0, error 0; takes priority over all inputs, including mid-SKIP.
REQ-030 While rst is high, stack_push, stack_pop, pc_load, exec_en and skipping SHALL be 0.
REQ-031 The downstream stack has no reset; on rst the unit treats the stack as empty regardless of stack contents.

Structure
REQ-032 Opcode encodings (LOOP_OPEN, LOOP_CLOSE, others) and state encodings SHALL live in the shared package bf_defs, common with the decoder.
REQ-033 The unit SHALL be a single module; the skip counter MAY be a sub-module nest_counter (load, inc, dec, all-ones flag).

Verification
REQ-034 Reset, then '[' at pc=4 with cell_zero=0 -> stack_push=1, stack_pushd=5, depth=1.
REQ-035 Then ']' at pc=9, stack_top=5, cell_zero=0 -> pc_load=1, pc_target=5; repeat with cell_zero=1 -> stack_pop=1, depth=0.
REQ-036 '[' cell_zero=1, then stream '[',  '+', ']', '-', ']' -> skipping=1 and exec_en=0 throughout; RUN after the final ']'; the next '+' gives exec_en=1.
REQ-037 33 '[' with cell_zero=0 (STACK_ADDR_WIDTH=5) -> 32 pushes, 33rd no push, error=1 from the next cycle.
REQ-038 ']' at depth 0 -> no pop, error=1; then rst -> error=0, depth=0.
REQ-039 rst asserted during SKIP with skip counter 3 -> RUN next cycle, skipping=0, a following '+' gives exec_en=1.
